qspi_seq_4x: RTL and testbench
==============================

QSPI_SEQ_4X -- requirements
Module: qspi_seq_4x

Interface
REQ-001 Parameter N_CS, default 2, number of chip selects (1..4).
REQ-002 Parameter RD_LAT, default 2, clk_1x cycles from a clock-driving cycle on phy_clk_o to the cycle its sampled data appears on phy_io_i (1..4).
REQ-003 clk_1x  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  byte command valid.
REQ-006 cmd_ready  output  1  byte command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_data  input  8  byte to transmit (ignored for reads).
REQ-008 cmd_quad  input  1  0 = single-bit (io0 out, io1 in); 1 = quad.
REQ-009 cmd_rd  input  1  1 = receive byte, 0 = transmit byte.
REQ-010 cmd_last  input  1  deselect after this byte.
REQ-011 cmd_cs  input  2  chip-select index; used only on the first byte of a transaction.
REQ-012 rsp_valid  output  1  one-cycle pulse, received byte valid; no backpressure.
REQ-013 rsp_data  output  8  received byte.
REQ-014 busy  output  1  high whenever state is not IDLE or a read response is pending.
REQ-015 phy_io_o  output  16 / phy_io_oe output 4 / phy_clk_o output 4 / phy_cs_o output N_CS (active-high) / phy_io_i input 16: the 4x PHY-side bus.

Function
REQ-016 Each clk_1x cycle carries 4 phases; phase p uses phy_io_o/phy_io_i bits [15-4p:12-4p] and phy_clk_o bit [3-p].
REQ-017 A clocking cycle drives phy_clk_o = 4'b0101: two SPI bit periods, bit A in phases 0/1 and bit B in phases 2/3. An idle cycle drives 4'b0000.
REQ-018 Data is MSB first. Quad sends bits [7:4] as bit A and [3:0] as bit B (one cycle per byte). Single sends bits 7-2k and 6-2k on io0 in cycle k=0..3 (four cycles per byte).
REQ-019 phy_io_oe: 4'b1111 for quad tx, 4'b0001 for single tx, 4'b0000 for any rx and for non-SHIFT states.
REQ-020 States: IDLE, SELECT, SHIFT, HOLD, DESEL.
REQ-021 IDLE: cmd_ready=1, phy_cs_o all zero; on accept, latch byte and cs index, go to SELECT.
REQ-022 SELECT: phy_cs_o[cs]=1, clock idle, one cycle, then SHIFT.
REQ-023 SHIFT: clocking cycles per REQ-018. cmd_ready=1 only in the final cycle of a byte, and only when the current byte is not last. An accept there starts the next byte back-to-back in the following cycle.
REQ-024 At the end of a non-last byte with no accept, go to HOLD: cs held, clock idle, oe 0, cmd_ready=1. An accept returns to SHIFT the next cycle.
REQ-025 At the end of a last byte, go to DESEL: cs held, clock idle, one cycle, then IDLE.
REQ-026 cmd_cs on non-first bytes is ignored. An index >= N_CS selects no line, but sequencing proceeds normally.
REQ-027 Every rx clocking cycle pushes a tag {quad, final-of-byte} into an RD_LAT-deep delay line.
REQ-028 When a tag emerges, sample phy_io_i phase 1 nibble as bit A and phase 3 nibble as bit B. Quad uses the full nibble; single uses bit io1 only. Shift the samples into the rx register.
REQ-029 Read latency: if a read byte's final SHIFT cycle is T, rsp_valid=1 in cycle T+RD_LAT+1 with rsp_data complete. rsp_data holds until the next response.
REQ-030 Tx bytes produce no rsp_valid. Back-to-back reads produce one rsp_valid per cycle in quad mode.
REQ-031 A new transaction may start in IDLE while earlier responses are still in the delay line; those responses complete unaffected.

Reset
REQ-032 On rst_n low, the block asynchronously enters IDLE and drives: phy_cs_o=0, phy_clk_o=0, phy_io_oe=0, phy_io_o=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=0.
REQ-033 Reset clears the delay line and rx register; a transfer in progress is abandoned without any response.
REQ-034 cmd_ready rises in the first cycle after rst_n deasserts.

Verification
REQ-035 Quad tx 0xA5, last, cs=1: SELECT cycle with cs=2'b10; one SHIFT cycle with phy_io_o=16'hAA55, oe=4'hF, clk=4'b0101; one DESEL cycle; then cs=0.
REQ-036 Single tx 0x9C: four cycles, io0 bit pairs (1,0),(0,1),(1,1),(0,0), oe=4'b0001.
REQ-037 Quad rx, RD_LAT=2, with phy_io_i phase1 nibble=4'h3 and phase3 nibble=4'hC in cycle T+2: rsp_valid at T+3 with rsp_data=0x3C.
REQ-038 Four back-to-back quad rx bytes with cmd_valid held: four SHIFT cycles with no gap, four consecutive rsp_valid pulses.
REQ-039 Non-last byte followed by cmd_valid low for 3 cycles: 3 HOLD cycles with cs held and clk=0, then the next byte shifts.
REQ-040 rst_n asserted mid-SHIFT of a read: outputs go to reset values immediately, and no rsp_valid follows after release.

Source files
------------

// File: rtl/qspi_seq_4x.sv
// qspi_seq_4x: byte-level command sequencer for a 4x-oversampled quad/single SPI PHY.
// Each clk_1x cycle carries four PHY phases (two SPI bit periods). Commands are
// accepted one byte at a time; reads come back as one-cycle rsp_valid pulses after
// the PHY round-trip latency RD_LAT.
module qspi_seq_4x #(
   parameter int N_CS   = 2,
   parameter int RD_LAT = 2
) (
   input  logic            clk_1x,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [7:0]      cmd_data,
   input  logic            cmd_quad,
   input  logic            cmd_rd,
   input  logic            cmd_last,
   input  logic [1:0]      cmd_cs,
   output logic            rsp_valid,
   output logic [7:0]      rsp_data,
   output logic            busy,
   output logic [15:0]     phy_io_o,
   output logic [3:0]      phy_io_oe,
   output logic [3:0]      phy_clk_o,
   output logic [N_CS-1:0] phy_cs_o,
   input  logic [15:0]     phy_io_i
);

   typedef enum logic [2:0] {IDLE, SELECT, SHIFT, HOLD, DESEL} state_t;

   state_t            state, state_nxt;
   logic [7:0]        byte_q;
   logic              quad_q, rd_q, last_q;
   logic [1:0]        cs_q;
   logic [1:0]        cnt_q;
   logic              run_q;
   logic              load;
   logic              byte_end;
   logic              push;
   logic [7:0]        tx_sh;
   logic [RD_LAT-1:0] tag_v, tag_quad, tag_fin;
   logic [7:0]        rx_q, rx_nxt;
   logic [3:0]        nib_a, nib_b;
   logic              unused_io;

   // A byte ends after one cycle in quad mode, after four cycles in single mode
   assign byte_end = (state == SHIFT) && (quad_q || (cnt_q == 2'd3));
   assign push     = (state == SHIFT) && rd_q;
   assign tx_sh    = byte_q << {cnt_q, 1'b0};
   assign nib_a    = phy_io_i[11:8];
   assign nib_b    = phy_io_i[3:0];
   assign unused_io = ^{phy_io_i[15:12], phy_io_i[7:4]};
   assign busy     = (state != IDLE) || (|tag_v);

   // State register; run_q keeps cmd_ready low until the first edge out of reset
   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         run_q <= 1'b0;
      end else begin
         state <= state_nxt;
         run_q <= 1'b1;
      end
   end

   // Next-state and handshake decode; cmd_valid is used only where cmd_ready is known high
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = run_q;
            if (run_q && cmd_valid) begin
               load      = 1'b1;
               state_nxt = SELECT;
            end
         end
         SELECT: state_nxt = SHIFT;
         SHIFT: begin
            if (byte_end) begin
               if (last_q) begin
                  state_nxt = DESEL;
               end else begin
                  cmd_ready = 1'b1;
                  if (cmd_valid) load = 1'b1;
                  else           state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         DESEL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the accepted byte; the chip-select index is taken only on a transaction's first byte
   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) begin
         byte_q <= '0;
         quad_q <= 1'b0;
         rd_q   <= 1'b0;
         last_q <= 1'b0;
         cs_q   <= '0;
         cnt_q  <= '0;
      end else begin
         if (load) begin
            byte_q <= cmd_data;
            quad_q <= cmd_quad;
            rd_q   <= cmd_rd;
            last_q <= cmd_last;
            cnt_q  <= '0;
            if (state == IDLE) cs_q <= cmd_cs;
         end else if (state == SHIFT) begin
            cnt_q <= cnt_q + 2'd1;
         end
      end
   end

   // PHY drive: chip select held from SELECT through DESEL, clocks and data only in SHIFT
   always_comb begin
      phy_cs_o  = '0;
      phy_clk_o = 4'b0000;
      phy_io_o  = 16'h0000;
      phy_io_oe = 4'b0000;
      for (int i = 0; i < N_CS; i++) begin
         if ((state != IDLE) && (cs_q == 2'(i))) phy_cs_o[i] = 1'b1;
      end
      if (state == SHIFT) begin
         phy_clk_o = 4'b0101;
         if (!rd_q) begin
            if (quad_q) begin
               phy_io_o  = {byte_q[7:4], byte_q[7:4], byte_q[3:0], byte_q[3:0]};
               phy_io_oe = 4'b1111;
            end else begin
               phy_io_o  = {3'b000, tx_sh[7], 3'b000, tx_sh[7], 3'b000, tx_sh[6], 3'b000, tx_sh[6]};
               phy_io_oe = 4'b0001;
            end
         end
      end
   end

   // Read tags travel RD_LAT cycles to line up with the returning PHY samples
   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) begin
         tag_v    <= '0;
         tag_quad <= '0;
         tag_fin  <= '0;
      end else begin
         tag_v[0]    <= push;
         tag_quad[0] <= quad_q;
         tag_fin[0]  <= byte_end;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v[i]    <= tag_v[i-1];
            tag_quad[i] <= tag_quad[i-1];
            tag_fin[i]  <= tag_fin[i-1];
         end
      end
   end

   // Quad takes both nibbles whole; single shifts in io1 of bit A then bit B
   always_comb begin
      rx_nxt = tag_quad[RD_LAT-1] ? {nib_a, nib_b} : {rx_q[5:0], nib_a[1], nib_b[1]};
   end

   // Capture returning samples and publish a completed byte as a one-cycle pulse
   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) begin
         rx_q      <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (tag_v[RD_LAT-1]) begin
            rx_q <= rx_nxt;
            if (tag_fin[RD_LAT-1]) begin
               rsp_valid <= 1'b1;
               rsp_data  <= rx_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_qspi_seq_4x.sv
// tb_qspi_seq_4x: builds a cycle-by-cycle expected timeline from transaction
// descriptions, drives the DUT from it and compares every output every cycle.
module tb_qspi_seq_4x;

   localparam int N_CS   = 2;
   localparam int RD_LAT = 2;
   localparam int MAXC   = 3000;

   logic            clk_1x = 1'b0;
   logic            rst_n  = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [7:0]      cmd_data = '0;
   logic            cmd_quad = 1'b0;
   logic            cmd_rd = 1'b0;
   logic            cmd_last = 1'b0;
   logic [1:0]      cmd_cs = '0;
   logic            rsp_valid;
   logic [7:0]      rsp_data;
   logic            busy;
   logic [15:0]     phy_io_o;
   logic [3:0]      phy_io_oe;
   logic [3:0]      phy_clk_o;
   logic [N_CS-1:0] phy_cs_o;
   logic [15:0]     phy_io_i = '0;

   qspi_seq_4x #(.N_CS(N_CS), .RD_LAT(RD_LAT)) dut (
      .clk_1x(clk_1x), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .cmd_quad(cmd_quad), .cmd_rd(cmd_rd), .cmd_last(cmd_last), .cmd_cs(cmd_cs),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .phy_io_o(phy_io_o), .phy_io_oe(phy_io_oe), .phy_clk_o(phy_clk_o),
      .phy_cs_o(phy_cs_o), .phy_io_i(phy_io_i)
   );

   always #5 clk_1x = ~clk_1x;

   typedef struct {
      logic [7:0] data;
      logic       quad;
      logic       rd;
      logic       last;
      int         gap;
   } byte_t;

   // stimulus per cycle
   logic            s_valid[MAXC];
   logic [7:0]      s_data[MAXC];
   logic            s_quad[MAXC], s_rd[MAXC], s_last[MAXC];
   logic [1:0]      s_cs[MAXC];
   logic [15:0]     s_io[MAXC];
   // expectations per cycle
   logic            e_ready[MAXC], e_busy[MAXC], e_rspv[MAXC];
   logic [7:0]      e_rspd[MAXC], e_rspval[MAXC];
   logic [N_CS-1:0] e_cs[MAXC];
   logic [3:0]      e_clk[MAXC], e_oe[MAXC];
   logic [15:0]     e_io[MAXC];
   logic            e_rx[MAXC], e_rxq[MAXC], e_rxfin[MAXC];

   byte_t cur[$];
   int    tc;
   int    ncyc;
   int    checks = 0;
   int    errors = 0;

   task automatic cmp(input string name, input int t, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, t, act, req);
      end
   endtask

   task automatic clearStim(input int t);
      s_valid[t] = 1'b0;
      s_data[t]  = 8'($urandom);
      s_quad[t]  = 1'($urandom);
      s_rd[t]    = 1'($urandom);
      s_last[t]  = 1'($urandom);
      s_cs[t]    = 2'($urandom);
   endtask

   task automatic setIdle(input int t);
      clearStim(t);
      e_ready[t] = 1'b1; e_busy[t] = 1'b0; e_cs[t] = '0;
      e_clk[t] = 4'h0; e_oe[t] = 4'h0; e_io[t] = 16'h0;
   endtask

   task automatic setHeld(input int t, input logic [N_CS-1:0] sel);
      clearStim(t);
      e_ready[t] = 1'b0; e_busy[t] = 1'b1; e_cs[t] = sel;
      e_clk[t] = 4'h0; e_oe[t] = 4'h0; e_io[t] = 16'h0;
   endtask

   task automatic present(input int t, input byte_t b, input logic [1:0] cs);
      s_valid[t] = 1'b1; s_data[t] = b.data; s_quad[t] = b.quad;
      s_rd[t] = b.rd; s_last[t] = b.last; s_cs[t] = cs;
   endtask

   task automatic addByte(input logic [7:0] d, input logic q, input logic r, input logic l, input int g);
      byte_t b;
      b.data = d; b.quad = q; b.rd = r; b.last = l; b.gap = g;
      cur.push_back(b);
   endtask

   // Lay one transaction (held in cur) onto the timeline starting at tc
   task automatic buildTxn(input int idle_gap, input logic [1:0] cs);
      logic [N_CS-1:0] sel;
      logic [3:0]      nib;
      logic [7:0]      d;
      int              n;
      sel = '0;
      if (int'(cs) < N_CS) sel[cs] = 1'b1;
      for (int g = 0; g < idle_gap; g++) begin setIdle(tc); tc++; end
      setIdle(tc); present(tc, cur[0], cs); tc++;
      setHeld(tc, sel);
      if (cur.size() > 1 && cur[1].gap == 0) present(tc, cur[1], 2'($urandom));
      tc++;
      for (int b = 0; b < cur.size(); b++) begin
         n = cur[b].quad ? 1 : 4;
         d = cur[b].data;
         for (int k = 0; k < n; k++) begin
            setHeld(tc, sel);
            e_clk[tc] = 4'b0101;
            e_ready[tc] = (k == n - 1) && !cur[b].last;
            if (cur[b].rd) begin
               e_rx[tc] = 1'b1; e_rxq[tc] = cur[b].quad; e_rxfin[tc] = (k == n - 1);
            end else begin
               e_oe[tc] = cur[b].quad ? 4'b1111 : 4'b0001;
               for (int p = 0; p < 4; p++) begin
                  if (cur[b].quad) nib = (p < 2) ? d[7:4] : d[3:0];
                  else             nib = {3'b000, (p < 2) ? d[7 - 2*k] : d[6 - 2*k]};
                  e_io[tc][15 - 4*p -: 4] = nib;
               end
            end
            if (!cur[b].last && cur[b+1].gap == 0) present(tc, cur[b+1], 2'($urandom));
            tc++;
         end
         if (!cur[b].last) begin
            for (int h = 0; h < cur[b+1].gap; h++) begin
               setHeld(tc, sel);
               e_ready[tc] = 1'b1;
               if (h == cur[b+1].gap - 1) present(tc, cur[b+1], 2'($urandom));
               tc++;
            end
         end
      end
      setHeld(tc, sel); tc++;
      cur.delete();
   endtask

   // Derive read responses and pending-read busy from the recorded rx cycles
   task automatic postProcess();
      logic [7:0] acc, held;
      logic [3:0] a, b;
      int         s;
      acc = 8'h00;
      for (int t = 0; t < ncyc; t++) begin
         if (e_rx[t]) begin
            s = t + RD_LAT;
            a = s_io[s][11:8];
            b = s_io[s][3:0];
            acc = e_rxq[t] ? {a, b} : {acc[5:0], a[1], b[1]};
            if (e_rxfin[t]) begin e_rspv[s + 1] = 1'b1; e_rspval[s + 1] = acc; end
            for (int u = t + 1; u <= t + RD_LAT; u++) e_busy[u] = 1'b1;
         end
      end
      held = 8'h00;
      for (int t = 0; t < ncyc; t++) begin
         if (e_rspv[t]) held = e_rspval[t];
         e_rspd[t] = held;
      end
   endtask

   task automatic applyStimulus(input int t);
      cmd_valid = s_valid[t]; cmd_data = s_data[t]; cmd_quad = s_quad[t];
      cmd_rd = s_rd[t]; cmd_last = s_last[t]; cmd_cs = s_cs[t];
      phy_io_i = s_io[t];
   endtask

   task automatic checkOutput(input int t);
      cmp("cmd_ready", t, 16'(cmd_ready), 16'(e_ready[t]));
      cmp("busy",      t, 16'(busy),      16'(e_busy[t]));
      cmp("phy_cs",    t, 16'(phy_cs_o),  16'(e_cs[t]));
      cmp("phy_clk",   t, 16'(phy_clk_o), 16'(e_clk[t]));
      cmp("phy_oe",    t, 16'(phy_io_oe), 16'(e_oe[t]));
      cmp("phy_io",    t, phy_io_o,       e_io[t]);
      cmp("rsp_valid", t, 16'(rsp_valid), 16'(e_rspv[t]));
      cmp("rsp_data",  t, 16'(rsp_data),  16'(e_rspd[t]));
   endtask

   task automatic checkAllZero(input string tag, input logic ready_req);
      cmp({tag, "_cs"},    -1, 16'(phy_cs_o),  16'h0);
      cmp({tag, "_clk"},   -1, 16'(phy_clk_o), 16'h0);
      cmp({tag, "_oe"},    -1, 16'(phy_io_oe), 16'h0);
      cmp({tag, "_io"},    -1, phy_io_o,       16'h0);
      cmp({tag, "_rspv"},  -1, 16'(rsp_valid), 16'h0);
      cmp({tag, "_rspd"},  -1, 16'(rsp_data),  16'h0);
      cmp({tag, "_busy"},  -1, 16'(busy),      16'h0);
      cmp({tag, "_ready"}, -1, 16'(cmd_ready), 16'(ready_req));
   endtask

   initial begin
      int t0, t1, t2, t4, nb, base;
      logic q, r;

      for (int t = 0; t < MAXC; t++) begin
         clearStim(t);
         s_io[t] = 16'($urandom);
         e_ready[t] = 1'b1; e_busy[t] = 1'b0; e_rspv[t] = 1'b0; e_rspd[t] = 8'h00;
         e_rspval[t] = 8'h00; e_cs[t] = '0; e_clk[t] = 4'h0; e_oe[t] = 4'h0; e_io[t] = 16'h0;
         e_rx[t] = 1'b0; e_rxq[t] = 1'b0; e_rxfin[t] = 1'b0;
      end
      tc = 0;

      // Directed: quad tx 0xA5 to cs 1
      t0 = tc + 1;
      addByte(8'hA5, 1'b1, 1'b0, 1'b1, 0);
      buildTxn(1, 2'd1);
      // Directed: single tx 0x9C
      t1 = tc;
      addByte(8'h9C, 1'b0, 1'b0, 1'b1, 0);
      buildTxn(0, 2'd0);
      // Directed: quad rx with known returning nibbles
      t2 = tc + 2 + 2;
      addByte(8'h00, 1'b1, 1'b1, 1'b1, 0);
      buildTxn(2, 2'd0);
      s_io[t2 + 2][11:8] = 4'h3;
      s_io[t2 + 2][3:0]  = 4'hC;
      // Directed: four back-to-back quad reads
      for (int i = 0; i < 4; i++) addByte(8'h00, 1'b1, 1'b1, i == 3, 0);
      buildTxn(0, 2'd1);
      // Directed: non-last byte then 3 hold cycles, to an unmapped cs index
      t4 = tc;
      addByte(8'h12, 1'b1, 1'b0, 1'b0, 0);
      addByte(8'h00, 1'b0, 1'b1, 1'b1, 3);
      buildTxn(0, 2'd3);
      // Random transactions
      while (tc < MAXC - 80) begin
         nb = $urandom_range(1, 5);
         for (int i = 0; i < nb; i++) begin
            q = 1'($urandom);
            r = 1'($urandom);
            addByte(8'($urandom), q, r, i == nb - 1, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
         end
         buildTxn($urandom_range(0, 2), 2'($urandom));
      end
      for (int i = 0; i < RD_LAT + 4; i++) begin setIdle(tc); tc++; end
      ncyc = tc;
      postProcess();

      // Hand-computed values that pin the model itself
      cmp("pin_sel_cs",  t0 + 1, 16'(e_cs[t0 + 1]),  16'h2);
      cmp("pin_a5_io",   t0 + 2, e_io[t0 + 2],       16'hAA55);
      cmp("pin_a5_oe",   t0 + 2, 16'(e_oe[t0 + 2]),  16'hF);
      cmp("pin_a5_clk",  t0 + 2, 16'(e_clk[t0 + 2]), 16'h5);
      cmp("pin_desel",   t0 + 3, 16'(e_cs[t0 + 3]),  16'h2);
      cmp("pin_idle_cs", t0 + 4, 16'(e_cs[t0 + 4]),  16'h0);
      cmp("pin_9c_k0",   t1 + 2, e_io[t1 + 2],       16'h1100);
      cmp("pin_9c_k1",   t1 + 3, e_io[t1 + 3],       16'h0011);
      cmp("pin_9c_k2",   t1 + 4, e_io[t1 + 4],       16'h1111);
      cmp("pin_9c_k3",   t1 + 5, e_io[t1 + 5],       16'h0000);
      cmp("pin_9c_oe",   t1 + 2, 16'(e_oe[t1 + 2]),  16'h1);
      cmp("pin_rx_v",    t2 + 3, 16'(e_rspv[t2 + 3]), 16'h1);
      cmp("pin_rx_d",    t2 + 3, 16'(e_rspd[t2 + 3]), 16'h3C);
      base = t4 + 2;
      for (int h = 1; h <= 3; h++) cmp("pin_hold_clk", base + h, 16'(e_clk[base + h]), 16'h0);
      cmp("pin_hold_shift", base + 4, 16'(e_clk[base + 4]), 16'h5);

      // Reset and release
      repeat (3) @(posedge clk_1x);
      @(negedge clk_1x);
      checkAllZero("reset", 1'b0);
      rst_n = 1'b1;
      #1;
      cmp("ready_at_release", -1, 16'(cmd_ready), 16'h0);

      for (int t = 0; t < ncyc; t++) begin
         @(posedge clk_1x);
         #1 applyStimulus(t);
         @(negedge clk_1x);
         checkOutput(t);
      end

      // Reset in the middle of a single-mode read
      @(posedge clk_1x);
      #1;
      cmd_valid = 1'b1; cmd_data = 8'h00; cmd_quad = 1'b0; cmd_rd = 1'b1; cmd_last = 1'b1; cmd_cs = 2'd0;
      @(posedge clk_1x);
      #1 cmd_valid = 1'b0;
      @(posedge clk_1x);
      @(posedge clk_1x);
      #3;
      cmp("midshift_clk", -1, 16'(phy_clk_o), 16'h5);
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset", 1'b0);
      @(negedge clk_1x);
      rst_n = 1'b1;
      #1;
      cmp("ready_at_release2", -1, 16'(cmd_ready), 16'h0);
      for (int i = 0; i < RD_LAT + 6; i++) begin
         phy_io_i = 16'($urandom);
         @(negedge clk_1x);
         checkAllZero("after_reset", 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
